adder_rr_scheduler: RTL
=======================

Name: adder_rr_scheduler

Overview:
- Shares one single-outstanding adder among NUM_REQ requesters.
- Round-robin arbitration. The block issues one operand pair at a time on the adder's input handshake, collects the sum on the adder's output handshake, and returns it to the originating requester.
- Sits between the per-client request ports and the adder instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 8, operand width; sum width is WIDTH+1
TIMEOUT, 64, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  input  1  single clock; all logic on posedge
rst  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester operand valid
req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
req_a  input  NUM_REQ*WIDTH  packed operand A; slice i belongs to requester i
req_b  input  NUM_REQ*WIDTH  packed operand B
rsp_valid  output  NUM_REQ  per-requester result valid; one-hot or zero
rsp_ready  input  NUM_REQ  per-requester result accept
rsp_data  output  WIDTH+1  result, shared by all requesters
add_valid  output  1  operand valid to adder
add_ready  input  1  adder ready
add_a  output  WIDTH  operand A to adder
add_b  output  WIDTH  operand B to adder
res_valid  input  1  adder result valid
res_ready  output  1  accept for the adder result
res_data  input  WIDTH+1  adder sum
grant_id  output  $clog2(NUM_REQ)  index of the current owner
busy  output  1  high in any state other than IDLE
err_timeout  output  1  watchdog error pulse (optional feature)

Behaviour:
- Reset state:
  - state=IDLE, last_grant=NUM_REQ-1, so requester 0 has first priority.
  - req_ready=0, rsp_valid=0, add_valid=0, res_ready=0.
  - add_a=0, add_b=0, rsp_data=0, grant_id=0, busy=0, err_timeout=0.
- Handshake rule on every interface: a transfer occurs on a cycle where valid&ready=1.
  - Once a source raises valid, it holds valid and data until the transfer.
  - The block obeys this on add_valid and rsp_valid, and relies on it for req_valid and res_valid.
- Round-robin selection:
  - The winner is the first i with req_valid[i]=1, searching from (last_grant+1) mod NUM_REQ upward with wrap-around.
  - last_grant updates only when a transaction completes in RETURN.
- IDLE:
  - req_ready = onehot(winner) combinationally when any req_valid is high, else 0.
  - On transfer: latch req_a/req_b slice into add_a/add_b, set grant_id=winner, add_valid<=1, go to ISSUE.
  - Request-to-add_valid latency is 1 cycle.
- ISSUE:
  - Hold add_valid and operands.
  - On add_valid&add_ready: add_valid<=0, res_ready<=1, go to WAIT.
- WAIT:
  - On res_valid&res_ready: rsp_data<=res_data, res_ready<=0, rsp_valid[grant_id]<=1, go to RETURN.
- RETURN:
  - Hold rsp_valid[grant_id] and rsp_data.
  - On rsp_ready[grant_id]: rsp_valid<=0, last_grant<=grant_id, go to IDLE.
  - The next request can be accepted on the following cycle. Requests are not accepted in the same cycle as the RETURN completion.
- Exclusivity:
  - req_ready is 0 outside IDLE, and at most one bit is set.
  - Only the granted requester sees rsp_valid.
  - rsp_ready bits of other requesters are ignored.
- Simultaneous requests: exactly one is granted per transaction. Others wait, holding valid.
- Minimum round trip with an always-ready adder and requester is 4 cycles + adder latency.
- Width: add_a and add_b pass operands unchanged. rsp_data carries the full WIDTH+1 sum, so no truncation occurs.
- Reset mid-operation:
  - All state returns to reset values on the next edge. The in-flight transaction is dropped without a response.
  - The adder is reset on the same rst, so no stale result arrives.
- busy = (state!=IDLE), registered.

Optional Feature:
- Macro: ADDER_RR_SCHEDULER_TIMEOUT_EN
- Defined:
  - A watchdog counter is cleared on entry to ISSUE and increments each cycle in ISSUE or WAIT.
  - When it reaches TIMEOUT, err_timeout pulses high for 1 cycle and add_valid and res_ready drop.
  - rsp_data<= all ones, rsp_valid[grant_id]<=1, go to RETURN.
- Undefined: no counter logic is built, err_timeout is tied 0, and the block waits indefinitely.

Test Plan:
- Single request: req_valid[0]=1, a=3, b=4, adder always ready -> add_a=3, add_b=4 one cycle after accept; rsp_valid[0] with rsp_data=7; no other rsp_valid bit set.
- Overflow width: requester 2 sends a=8'hFF, b=8'hFF -> rsp_data=9'h1FE.
- Fairness:
  - Stimulus: all 4 requesters hold valid continuously with distinct operands (i, 10*i).
  - Grant order: 0,1,2,3,0.
  - Each rsp_data: 11*i, delivered to requester i only.
- Backpressure:
  - Stimulus: adder holds ready low 5 cycles in ISSUE, and requester 1 holds rsp_ready low 3 cycles.
  - Required: add_valid and operands stable throughout; rsp_valid[1] and rsp_data stable; no second req_ready until RETURN completes.
- Reset mid-transaction: assert rst for 1 cycle while in WAIT -> all outputs at reset values on the next cycle; next grant goes to requester 0.
- Timeout (feature on, TIMEOUT=8): adder never asserts res_valid -> err_timeout pulses exactly 8 cycles after ISSUE entry; rsp_data=9'h1FF to the granted requester; return to IDLE after rsp_ready.

Source files
------------

// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler: round-robin sharing of one single-outstanding adder; ports clk/rst, req_* operand and rsp_* result handshakes per requester (packed slices, shared rsp_data), add_*/res_* adder handshakes, grant_id owner, busy, err_timeout watchdog pulse built only with ADDER_RR_SCHEDULER_TIMEOUT_EN
module adder_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [WIDTH:0]             rsp_data,
  output logic                       add_valid,
  input  logic                       add_ready,
  output logic [WIDTH-1:0]           add_a,
  output logic [WIDTH-1:0]           add_b,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic [WIDTH:0]             res_data,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       err_timeout
);
  localparam int GW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} state_t;
  state_t state, state_next;
  logic [GW-1:0] last_grant, winner, idx;
  logic [NUM_REQ-1:0] gnt_oh;
  logic any_req, timeout;
  assign any_req = |req_valid;
  assign gnt_oh = NUM_REQ'(1) << grant_id;
  always_comb begin
    winner = last_grant;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = GW'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[idx]) winner = idx;
    end
  end
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = any_req ? ISSUE : IDLE;
      ISSUE:   state_next = add_ready ? WAIT : ISSUE;
      WAIT:    state_next = res_valid ? RETURN : WAIT;
      RETURN:  state_next = rsp_ready[grant_id] ? IDLE : RETURN;
      default: state_next = IDLE;
    endcase
    if (timeout) state_next = RETURN;
  end
  always_comb begin
    req_ready = (state == IDLE && any_req) ? NUM_REQ'(1) << winner : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GW'(NUM_REQ - 1);
      grant_id   <= '0;
      add_valid  <= 1'b0;
      add_a      <= '0;
      add_b      <= '0;
      res_ready  <= 1'b0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      busy       <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= state_next != IDLE;
      if (state == IDLE && any_req) begin
        add_a     <= req_a[winner*WIDTH +: WIDTH];
        add_b     <= req_b[winner*WIDTH +: WIDTH];
        grant_id  <= winner;
        add_valid <= 1'b1;
      end
      if (state == ISSUE && add_ready) begin
        add_valid <= 1'b0;
        res_ready <= 1'b1;
      end
      if (state == WAIT && res_valid) begin
        rsp_data  <= res_data;
        res_ready <= 1'b0;
        rsp_valid <= gnt_oh;
      end
      if (state == RETURN && rsp_ready[grant_id]) begin
        rsp_valid  <= '0;
        last_grant <= grant_id;
      end
      if (timeout) begin
        add_valid <= 1'b0;
        res_ready <= 1'b0;
        rsp_data  <= '1;
        rsp_valid <= gnt_oh;
      end
    end
  end
`ifdef ADDER_RR_SCHEDULER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt;
  // counter sits at zero in IDLE/RETURN, so ISSUE always starts from zero
  assign timeout = (state == ISSUE || state == WAIT) && wd_cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      wd_cnt      <= (state == ISSUE || state == WAIT) ? wd_cnt + 1'b1 : '0;
      err_timeout <= timeout;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout = 1'b0;
  assign err_timeout = 1'b0;
`endif
endmodule
